// File: rtl/tl_seq_ctrl_pkg.sv
// Shared phase encodings and the CMD_/INT_ bit indices for the traffic-light sequencer.
// The tl_seq_ctrl build option TL_PED_REQ_EN does not change anything in this file.
`ifndef TL_SEQ_CTRL_DEFS
`define TL_SEQ_CTRL_DEFS
`define INT_FLAG_W 4
`define INT_INIT   0
`define INT_G      1
`define INT_Y      2
`define INT_R      3
`define CMD_FLAG_W 4
`define CMD_INIT   0
`define CMD_G      1
`define CMD_Y      2
`define CMD_R      3
`endif

package tl_seq_ctrl_pkg;

  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned INT_FLAG_W = `INT_FLAG_W;
  localparam int unsigned CMD_FLAG_W = `CMD_FLAG_W;
  localparam int unsigned INT_INIT   = `INT_INIT;
  localparam int unsigned INT_G      = `INT_G;
  localparam int unsigned INT_Y      = `INT_Y;
  localparam int unsigned INT_R      = `INT_R;
  localparam int unsigned CMD_INIT   = `CMD_INIT;
  localparam int unsigned CMD_G      = `CMD_G;
  localparam int unsigned CMD_Y      = `CMD_Y;
  localparam int unsigned CMD_R      = `CMD_R;

  typedef enum logic [PHASE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_GREEN  = 3'd2,
    ST_YELLOW = 3'd3,
    ST_RED    = 3'd4,
    ST_FAULT  = 3'd5
  } phase_e;

  // FAULT keeps the lights on red.
  function automatic logic [CMD_FLAG_W-1:0] phase_cmd(input phase_e s);
    logic [CMD_FLAG_W-1:0] c;
    c = '0;
    case (s)
      ST_INIT:           c[CMD_INIT] = 1'b1;
      ST_GREEN:          c[CMD_G]    = 1'b1;
      ST_YELLOW:         c[CMD_Y]    = 1'b1;
      ST_RED, ST_FAULT:  c[CMD_R]    = 1'b1;
      default:           c           = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tl_wdog.sv
// Per-phase watchdog: clearable, enabled, saturating counter with an expiry flag.
// With TL_PED_REQ_EN the count is exported for the pedestrian minimum-green check.
module tl_wdog #(
  parameter int unsigned W   = 12,
  parameter int unsigned MAX = 2047
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
`ifdef TL_PED_REQ_EN
  output logic [W-1:0] cnt,
`endif
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired_c = (cnt_q == W'(MAX));

`ifdef TL_PED_REQ_EN
  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/tl_seq_ctrl.sv
// Traffic-light phase sequencer: IDLE -> INIT -> (GREEN -> YELLOW -> RED)* with watchdog FAULT.
// Optional pedestrian early-exit from GREEN is built when TL_PED_REQ_EN is defined.
module tl_seq_ctrl
  import tl_seq_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_W   = 12,
  parameter int unsigned WDOG_MAX = 2047,
  parameter int unsigned CYC_W    = 8
`ifdef TL_PED_REQ_EN
  , parameter int unsigned MIN_GREEN = 64
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop_req,
  input  logic                   clr_fault,
  input  logic [`INT_FLAG_W-1:0] int_flags,
  output logic [`CMD_FLAG_W-1:0] cmd_flags,
  output logic                   cnt_rst,
  output logic [PHASE_W-1:0]     phase,
  output logic                   fault,
  output logic [CYC_W-1:0]       cycle_cnt
`ifdef TL_PED_REQ_EN
  , input logic                  ped_req
`endif
);

  phase_e state;
  logic   wdog_exp_c;
  logic   wdog_clr_c;
  logic   active_c;
  logic   done_c;
  logic   chg_c;

`ifdef TL_PED_REQ_EN
  logic [WDOG_W-1:0] wdog;
  logic              ped_lat;
`endif

  // Exit condition looks only at the current phase's own done flag.
  always_comb begin
    active_c = (state == ST_INIT) || (state == ST_GREEN) ||
               (state == ST_YELLOW) || (state == ST_RED);
    done_c = 1'b0;
    case (state)
      ST_INIT:   done_c = int_flags[`INT_INIT];
      ST_GREEN:  done_c = int_flags[`INT_G];
      ST_YELLOW: done_c = int_flags[`INT_Y];
      ST_RED:    done_c = int_flags[`INT_R];
      default:   done_c = 1'b0;
    endcase
`ifdef TL_PED_REQ_EN
    if ((state == ST_GREEN) && ped_lat && (wdog >= WDOG_W'(MIN_GREEN))) begin
      done_c = 1'b1;
    end
`endif
    chg_c = ((state == ST_IDLE) && start) ||
            (active_c && (done_c || wdog_exp_c)) ||
            ((state == ST_FAULT) && clr_fault);
    wdog_clr_c = chg_c || !active_c;
  end

  tl_wdog #(
    .W   (WDOG_W),
    .MAX (WDOG_MAX)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clr       (wdog_clr_c),
    .en        (active_c),
`ifdef TL_PED_REQ_EN
    .cnt       (wdog),
`endif
    .expired_c (wdog_exp_c)
  );

  // Done beats watchdog expiry when both occur in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt_rst   <= 1'b0;
      fault     <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cnt_rst <= 1'b0;
      if (active_c && !done_c && wdog_exp_c) begin
        state   <= ST_FAULT;
        cnt_rst <= 1'b1;
        fault   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state   <= ST_INIT;
              cnt_rst <= 1'b1;
            end
          end
          ST_INIT: begin
            if (done_c) begin
              state   <= ST_GREEN;
              cnt_rst <= 1'b1;
            end
          end
          ST_GREEN: begin
            if (done_c) begin
              state   <= ST_YELLOW;
              cnt_rst <= 1'b1;
            end
          end
          ST_YELLOW: begin
            if (done_c) begin
              state   <= ST_RED;
              cnt_rst <= 1'b1;
            end
          end
          ST_RED: begin
            if (done_c) begin
              cycle_cnt <= cycle_cnt + CYC_W'(1);
              if (stop_req) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_GREEN;
                cnt_rst <= 1'b1;
              end
            end
          end
          ST_FAULT: begin
            if (clr_fault) begin
              state <= ST_IDLE;
              fault <= 1'b0;
            end else begin
              cnt_rst <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TL_PED_REQ_EN
  // Sticky pedestrian request, dropped as the controller enters RED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_lat <= 1'b0;
    end else if ((state == ST_YELLOW) && done_c) begin
      ped_lat <= 1'b0;
    end else if (ped_req) begin
      ped_lat <= 1'b1;
    end
  end
`endif

  assign cmd_flags = phase_cmd(state);
  assign phase     = state;

endmodule

// File: tb/tb_tl_seq_ctrl.sv
// Scoreboard bench for tl_seq_ctrl: a stub datapath raises done flags, expected phase entries are queued.
// Pedestrian scenario is included when TL_PED_REQ_EN is defined.
module tb_tl_seq_ctrl;
  import tl_seq_ctrl_pkg::*;

  localparam int unsigned WDOG_W   = 12;
  localparam int unsigned WDOG_MAX = 100;
  localparam int unsigned CYC_W    = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  stop_req = 1'b0;
  logic                  clr_fault = 1'b0;
  logic [INT_FLAG_W-1:0] int_flags;
  logic [CMD_FLAG_W-1:0] cmd_flags;
  logic                  cnt_rst;
  logic [PHASE_W-1:0]    phase;
  logic                  fault;
  logic [CYC_W-1:0]      cycle_cnt;
`ifdef TL_PED_REQ_EN
  logic                  ped_req = 1'b0;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  tl_seq_ctrl #(
    .WDOG_W   (WDOG_W),
    .WDOG_MAX (WDOG_MAX),
    .CYC_W    (CYC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop_req  (stop_req),
    .clr_fault (clr_fault),
    .int_flags (int_flags),
    .cmd_flags (cmd_flags),
    .cnt_rst   (cnt_rst),
    .phase     (phase),
    .fault     (fault),
    .cycle_cnt (cycle_cnt)
`ifdef TL_PED_REQ_EN
    , .ped_req (ped_req)
`endif
  );

  // Stub datapath: phase counter cleared by cnt_rst, done flag when it reaches dur[]
  int unsigned dur [4];
  logic [3:0]  kill = 4'b0000;
  int unsigned dpc = 0;

  always @(posedge clk) begin
    if (cnt_rst) dpc <= 0;
    else         dpc <= dpc + 1;
  end

  always_comb begin
    int_flags = '0;
    int_flags[INT_INIT] = cmd_flags[CMD_INIT] & ~cnt_rst & (dpc == dur[INT_INIT]) & ~kill[INT_INIT];
    int_flags[INT_G]    = cmd_flags[CMD_G]    & ~cnt_rst & (dpc == dur[INT_G])    & ~kill[INT_G];
    int_flags[INT_Y]    = cmd_flags[CMD_Y]    & ~cnt_rst & (dpc == dur[INT_Y])    & ~kill[INT_Y];
    int_flags[INT_R]    = cmd_flags[CMD_R]    & ~cnt_rst & (dpc == dur[INT_R])    & ~kill[INT_R];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CMD_FLAG_W-1:0] exp_cmd(input logic [PHASE_W-1:0] ph);
    case (ph)
      ST_INIT:          return CMD_FLAG_W'(1) << CMD_INIT;
      ST_GREEN:         return CMD_FLAG_W'(1) << CMD_G;
      ST_YELLOW:        return CMD_FLAG_W'(1) << CMD_Y;
      ST_RED, ST_FAULT: return CMD_FLAG_W'(1) << CMD_R;
      default:          return '0;
    endcase
  endfunction

  typedef struct {
    logic [PHASE_W-1:0] ph;
    logic [CYC_W-1:0]   cc;
    logic               flt;
    int unsigned        dwell;
    bit                 chk_dwell;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic push(input logic [PHASE_W-1:0] ph, input int cc, input logic flt,
                      input int unsigned dwell, input bit chkd);
    exp_t e;
    e.ph = ph; e.cc = CYC_W'(cc); e.flt = flt; e.dwell = dwell; e.chk_dwell = chkd;
    sb.push_back(e);
  endtask

  // Monitor: every phase change pops one expected entry; cnt_rst checked every cycle
  logic [PHASE_W-1:0] prev_ph = ST_IDLE;
  int unsigned        dwell_cnt = 0;

  always @(negedge clk) begin
    if (phase != prev_ph) begin
      chk("sb_avail", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("phase", 32'(phase), 32'(mon_e.ph));
        chk("cmd_flags", 32'(cmd_flags), 32'(exp_cmd(mon_e.ph)));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(mon_e.cc));
        chk("fault", 32'(fault), 32'(mon_e.flt));
        if (mon_e.chk_dwell) chk("dwell", dwell_cnt, mon_e.dwell);
      end
      dwell_cnt = 1;
    end else begin
      dwell_cnt++;
    end
    chk("cnt_rst", 32'(cnt_rst),
        32'(((phase != prev_ph) && (phase != ST_IDLE)) || (phase == ST_FAULT)));
    prev_ph = phase;
  end

  task automatic wait_phase(input logic [PHASE_W-1:0] ph, input int budget);
    int n = 0;
    while ((phase != ph) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (phase != ph) chk("wait_phase", 32'(phase), 32'(ph));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    dur[INT_INIT] = 20; dur[INT_G] = 12; dur[INT_Y] = 8; dur[INT_R] = 15;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_phase", 32'(phase), 32'(ST_IDLE));
    chk("rst_cmd", 32'(cmd_flags), 32'd0);
    chk("rst_cnt_rst", 32'(cnt_rst), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Normal cycling, stop requested mid-GREEN, stray clr_fault ignored
    push(ST_INIT, 0, 0, 0, 0);
    push(ST_GREEN, 0, 0, 22, 1);
    push(ST_YELLOW, 0, 0, 14, 1);
    push(ST_RED, 0, 0, 10, 1);
    push(ST_GREEN, 1, 0, 17, 1);
    push(ST_YELLOW, 1, 0, 14, 1);
    push(ST_RED, 1, 0, 10, 1);
    push(ST_IDLE, 2, 0, 17, 1);
    start = 1'b1;
    wait_phase(ST_INIT, 10);
    start = 1'b0;
    wait_phase(ST_YELLOW, 200);
    wait_phase(ST_GREEN, 200);
    repeat (5) @(negedge clk);
    stop_req = 1'b1;
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    wait_phase(ST_IDLE, 200);
    stop_req = 1'b0;
    repeat (5) @(negedge clk);

    // YELLOW done flag never comes: watchdog FAULT, then clr_fault
    kill[INT_Y] = 1'b1;
    push(ST_INIT, 2, 0, 0, 0);
    push(ST_GREEN, 2, 0, 22, 1);
    push(ST_YELLOW, 2, 0, 14, 1);
    push(ST_FAULT, 2, 1, WDOG_MAX + 1, 1);
    start = 1'b1;
    wait_phase(ST_INIT, 10);
    start = 1'b0;
    wait_phase(ST_FAULT, 400);
    repeat (8) @(negedge clk);
    chk("fault_hold", 32'(fault), 32'd1);
    chk("fault_cmd", 32'(cmd_flags), 32'(CMD_FLAG_W'(1) << CMD_R));
    push(ST_IDLE, 2, 0, 0, 0);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    wait_phase(ST_IDLE, 10);
    kill = 4'b0000;
    repeat (3) @(negedge clk);

    // GREEN done in the very cycle the watchdog saturates; stop_req held from the start
    dur[INT_G] = WDOG_MAX - 1;
    stop_req = 1'b1;
    push(ST_INIT, 2, 0, 0, 0);
    push(ST_GREEN, 2, 0, 22, 1);
    push(ST_YELLOW, 2, 0, WDOG_MAX + 1, 1);
    push(ST_RED, 2, 0, 10, 1);
    push(ST_IDLE, 3, 0, 17, 1);
    start = 1'b1;
    wait_phase(ST_INIT, 10);
    start = 1'b0;
    wait_phase(ST_GREEN, 100);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_phase(ST_IDLE, 400);
    stop_req = 1'b0;
    dur[INT_G] = 12;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of RED
    push(ST_INIT, 3, 0, 0, 0);
    push(ST_GREEN, 3, 0, 22, 1);
    push(ST_YELLOW, 3, 0, 14, 1);
    push(ST_RED, 3, 0, 10, 1);
    push(ST_IDLE, 0, 0, 0, 0);
    start = 1'b1;
    wait_phase(ST_INIT, 10);
    start = 1'b0;
    wait_phase(ST_RED, 200);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_phase", 32'(phase), 32'(ST_IDLE));
    chk("async_cmd", 32'(cmd_flags), 32'd0);
    chk("async_cnt_rst", 32'(cnt_rst), 32'd0);
    chk("async_fault", 32'(fault), 32'd0);
    chk("async_cycle_cnt", 32'(cycle_cnt), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Short phases, 257 cycles so cycle_cnt wraps past 255
    dur[INT_INIT] = 0; dur[INT_G] = 0; dur[INT_Y] = 0; dur[INT_R] = 0;
    push(ST_INIT, 0, 0, 0, 0);
    for (int i = 0; i < 257; i++) begin
      push(ST_GREEN, i, 0, 2, 1);
      push(ST_YELLOW, i, 0, 2, 1);
      push(ST_RED, i, 0, 2, 1);
    end
    push(ST_IDLE, 257, 0, 2, 1);
    start = 1'b1;
    wait_phase(ST_INIT, 10);
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wait_phase(ST_RED, 50);
      wait_phase(ST_GREEN, 50);
    end
    stop_req = 1'b1;
    wait_phase(ST_IDLE, 50);
    stop_req = 1'b0;
    repeat (3) @(negedge clk);

`ifdef TL_PED_REQ_EN
    // Pedestrian request at GREEN cycle 10 cuts GREEN short once, then the latch is gone
    dur[INT_INIT] = 20; dur[INT_G] = 90; dur[INT_Y] = 8; dur[INT_R] = 15;
    push(ST_INIT, 1, 0, 0, 0);
    push(ST_GREEN, 1, 0, 22, 1);
    push(ST_YELLOW, 1, 0, 65, 1);
    push(ST_RED, 1, 0, 10, 1);
    push(ST_GREEN, 2, 0, 17, 1);
    push(ST_YELLOW, 2, 0, 92, 1);
    push(ST_RED, 2, 0, 10, 1);
    push(ST_IDLE, 3, 0, 17, 1);
    start = 1'b1;
    wait_phase(ST_INIT, 10);
    start = 1'b0;
    wait_phase(ST_GREEN, 100);
    repeat (10) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    wait_phase(ST_RED, 200);
    wait_phase(ST_GREEN, 100);
    stop_req = 1'b1;
    wait_phase(ST_IDLE, 300);
    stop_req = 1'b0;
    repeat (3) @(negedge clk);
`endif

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tl_seq_ctrl.md
Name: tl_seq_ctrl

Overview:
- Phase sequencer for the traffic-light datapath (dp).
- Drives one-hot cmd_flags and the cnt_rst pulse, and consumes the per-phase done flags (int_flags).
- Runs INIT once after start, then cycles GREEN -> YELLOW -> RED.
- Adds a per-phase watchdog, a graceful stop, and a completed-cycle counter for the top level.

Parameters:
- WDOG_W, 12, width of the per-phase watchdog counter.
- WDOG_MAX, 2047, cycles allowed in any phase before FAULT.
- CYC_W, 8, width of the completed-cycle counter.
- MIN_GREEN, 64, minimum GREEN cycles before a pedestrian early exit (only used with PED_REQ_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  level; leaves IDLE when high.
- stop_req  in  1  level; sampled at the RED exit.
- clr_fault  in  1  pulse; leaves FAULT.
- int_flags  in  `INT_FLAG_W  done flags from dp, indexed by `INT_INIT/`INT_G/`INT_Y/`INT_R.
- cmd_flags  out  `CMD_FLAG_W  one-hot phase command to dp; all-zero in IDLE.
- cnt_rst  out  1  counter clear to dp.
- phase  out  3  current state encoding.
- fault  out  1  high while in FAULT.
- cycle_cnt  out  CYC_W  completed G-Y-R cycles.
- ped_req  in  1  only with PED_REQ_EN.

Behaviour:
- Reset: clk, reset asynchronous active-high. Clears state=IDLE, cnt_rst=0, fault=0, cycle_cnt=0, watchdog=0, ped latch=0.
- States: IDLE, INIT, GREEN, YELLOW, RED, FAULT. The state register is the only source of truth.
- cmd_flags is a combinational decode of the state:
  - INIT -> bit `CMD_INIT
  - GREEN -> `CMD_G
  - YELLOW -> `CMD_Y
  - RED and FAULT -> `CMD_R
  - IDLE -> 0
- cnt_rst is registered. It is high for exactly the first cycle of every newly entered INIT/GREEN/YELLOW/RED state, and held high throughout FAULT.
- Phase exit condition: in phase P, the controller samples only int_flags[P]. Flags of other phases are ignored, so a stale flag from the previous phase has no effect.
- Transitions take effect the cycle after the condition:
  - IDLE -> INIT when start=1.
  - INIT -> GREEN on int_flags[`INT_INIT].
  - GREEN -> YELLOW on int_flags[`INT_G].
  - YELLOW -> RED on int_flags[`INT_Y].
  - RED -> IDLE on int_flags[`INT_R] if stop_req=1, else RED -> GREEN.
  - Any of INIT/GREEN/YELLOW/RED -> FAULT when watchdog==WDOG_MAX and the done flag is low.
  - FAULT -> IDLE on clr_fault.
- Watchdog:
  - Cleared on every state change.
  - Increments each cycle in INIT/GREEN/YELLOW/RED.
  - Saturates at WDOG_MAX; holds 0 in IDLE/FAULT.
- Simultaneous events:
  - done flag and watchdog expiry in the same cycle -> done wins (normal transition).
  - stop_req is ignored in every state except at the RED exit.
  - start is ignored outside IDLE.
  - clr_fault is ignored outside FAULT.
- cycle_cnt increments by 1 on each RED exit (to GREEN or IDLE). It wraps from 2^CYC_W-1 to 0 and is not cleared by FAULT.
- fault is registered: 1 from the first FAULT cycle, 0 from the first IDLE cycle.

Optional Feature:
- Macro: TL_PED_REQ_EN.
- With the macro defined:
  - The ped_req port exists. A sticky latch sets on ped_req=1 in any state.
  - In GREEN with latch=1 and watchdog>=MIN_GREEN, the block moves to YELLOW next cycle without waiting for int_flags[`INT_G], and asserts cnt_rst normally.
  - The latch clears on entering RED.
- Without the macro:
  - No ped_req port and no latch.
  - GREEN exits only on the done flag.

Decomposition:
- State encodings (3-bit), PHASE_W, and the phase-to-cmd bit mapping go in def.v next to the existing CMD_/INT_ indices, shared with the top level and the bench.
- Natural sub-module: tl_wdog (clear/enable/saturating counter with an expired output). Everything else stays in tl_seq_ctrl.

Test Plan:
- Reset then start=1, connected to dp:
  - INIT cmd until the INIT done flag (~1023 cycles).
  - Then GREEN (~511), YELLOW (~510), RED (~1022).
  - cnt_rst high exactly one cycle at each entry; cycle_cnt=1 after the first RED exit.
- stop_req=1 asserted mid-GREEN: sequence continues through YELLOW and RED, then IDLE with cmd_flags=0 and cycle_cnt incremented once.
- Stub dp with int_flags tied to 0 in YELLOW:
  - FAULT entered after WDOG_MAX+1 YELLOW cycles; fault=1, cmd_flags=`CMD_R, cnt_rst held 1.
  - clr_fault -> IDLE, fault=0.
- Done flag forced in the same cycle watchdog reaches WDOG_MAX -> normal transition, fault stays 0.
- Async reset pulsed mid-RED -> outputs return to reset values immediately; cmd_flags=0 without waiting for a clock edge.
- With TL_PED_REQ_EN, ped_req pulsed at GREEN cycle 10 and MIN_GREEN=64 -> YELLOW entered at GREEN cycle 65 (watchdog 64); latch cleared at RED entry.
